// File: rtl/oled_pkg.sv
// Shared definitions for the OLED pixel streamer and the pixel renderers that feed it:
// frame geometry defaults, RGB565 colour type and the streamer FSM encoding.
package oled_pkg;

  localparam int OLED_WIDTH  = 96;
  localparam int OLED_HEIGHT = 64;
  localparam int RGB565_W    = 16;
  localparam int X_W         = 7;
  localparam int Y_W         = 6;

  typedef logic [RGB565_W-1:0] rgb565_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } oled_state_e;

  // Renderers build colours from 5/6/5-bit channels.
  function automatic rgb565_t rgb565_pack(input logic [4:0] r, input logic [5:0] g,
                                          input logic [4:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/oled_pixel_streamer_spi_shift16.sv
// 16-bit MSB-first serializer, SPI mode 3: sclk idles high, each bit spends CLK_DIV
// cycles low (data changes here) then CLK_DIV cycles high (display samples on the rise).
module spi_shift16
  import oled_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic [RGB565_W-1:0] data,
  output logic                sclk,
  output logic                mosi,
  output logic                bit_done,
  output logic [3:0]          bit_idx
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLK_DIV - 1);

  logic                active_q;
  logic                sclk_q;
  logic [RGB565_W-1:0] sr_q;
  logic [TW-1:0]       timer_q;
  logic [3:0]          bit_q;
  logic                phase_end;

  assign phase_end = (timer_q == T_LAST);
  assign bit_done  = active_q & sclk_q & phase_end;
  assign sclk      = sclk_q;
  assign mosi      = sr_q[RGB565_W-1];
  assign bit_idx   = bit_q;

  // The register shifts once more after bit 0, so mosi returns to 0 between words.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b1;
      sr_q     <= '0;
      timer_q  <= '0;
      bit_q    <= '0;
    end else if (load) begin
      active_q <= 1'b1;
      sclk_q   <= 1'b0;
      sr_q     <= data;
      timer_q  <= '0;
      bit_q    <= 4'd15;
    end else if (active_q) begin
      if (!phase_end) begin
        timer_q <= timer_q + TW'(1);
      end else begin
        timer_q <= '0;
        if (!sclk_q) begin
          sclk_q <= 1'b1;
        end else begin
          sr_q <= {sr_q[RGB565_W-2:0], 1'b0};
          if (bit_q == 4'd0) begin
            active_q <= 1'b0;
          end else begin
            sclk_q <= 1'b0;
            bit_q  <= bit_q - 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/oled_pixel_streamer.sv
// Streams one WIDTH x HEIGHT frame of RGB565 pixels to an OLED over SPI, asking an
// external renderer for each pixel by presenting (x,y) for one LOAD cycle.
module oled_pixel_streamer
  import oled_pkg::*;
#(
  parameter int WIDTH   = OLED_WIDTH,
  parameter int HEIGHT  = OLED_HEIGHT,
  parameter int CLK_DIV = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                frame_start,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  input  logic [RGB565_W-1:0] oled_data,
  output logic                busy,
  output logic                frame_done,
  output logic                spi_cs_n,
  output logic                spi_sclk,
  output logic                spi_mosi,
  output logic                spi_dc,
  output oled_state_e         dbg_state
);

  localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

  oled_state_e    state_q;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic           busy_q;
  logic           cs_n_q;
  logic           done_q;

  logic           shift_load;
  logic           bit_done;
  logic [3:0]     bit_idx;
  logic           word_done;

  assign shift_load = (state_q == ST_LOAD);
  assign word_done  = bit_done && (bit_idx == 4'd0);

  spi_shift16 #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (shift_load),
    .data     (oled_data),
    .sclk     (spi_sclk),
    .mosi     (spi_mosi),
    .bit_done (bit_done),
    .bit_idx  (bit_idx)
  );

  // frame_done is raised on the edge leaving DONE, so it is seen in the first idle
  // cycle; a frame_start held through that cycle begins the next frame immediately.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            state_q <= ST_LOAD;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b1;
            cs_n_q  <= 1'b0;
          end
        end
        ST_LOAD: state_q <= ST_SHIFT;
        ST_SHIFT: begin
          if (word_done) begin
            if (x_q < X_LAST) begin
              x_q     <= x_q + X_W'(1);
              state_q <= ST_LOAD;
            end else if (y_q < Y_LAST) begin
              x_q     <= '0;
              y_q     <= y_q + Y_W'(1);
              state_q <= ST_LOAD;
            end else begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          cs_n_q  <= 1'b1;
          x_q     <= '0;
          y_q     <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Every word is pixel data; command bytes are sent by other logic.
  assign spi_dc     = 1'b1;
  assign x          = x_q;
  assign y          = y_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign spi_cs_n   = cs_n_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Bench for oled_pixel_streamer on a small 5x3 frame with CLK_DIV=2: words are rebuilt
// from MOSI on sclk rises and compared against a raster-order expected queue.
module tb_oled_pixel_streamer;
  import oled_pkg::*;

  localparam int TW_       = 5;
  localparam int TH_       = 3;
  localparam int TD        = 2;
  localparam int NPIX      = TW_ * TH_;
  localparam int PIX_CYC   = 1 + 32 * TD;
  localparam int FRAME_CYC = NPIX * PIX_CYC;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          frame_start = 1'b0;
  logic [6:0]    x;
  logic [5:0]    y;
  logic [15:0]   oled_data;
  logic          busy, frame_done, spi_cs_n, spi_sclk, spi_mosi, spi_dc;
  oled_state_e   dbg_state;

  logic          const_en = 1'b0;
  logic [15:0]   const_val = '0;
  logic [15:0]   key = '0;

  logic [15:0]   exp_q[$];
  int            exp_done_q[$];

  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;
  bit            in_reset = 1'b1;
  int            nb = 0;
  int            low_run = 0;
  logic [15:0]   sh = '0;
  logic          prev_sclk = 1'b1;
  logic          prev_busy = 1'b0;

  oled_pixel_streamer #(
    .WIDTH   (TW_),
    .HEIGHT  (TH_),
    .CLK_DIV (TD)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .x           (x),
    .y           (y),
    .oled_data   (oled_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .spi_cs_n    (spi_cs_n),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_dc      (spi_dc),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // renderer: colour is a function of the coordinates, scrambled per frame
  assign oled_data = const_en ? const_val : ({x, y, 3'b000} ^ key);

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm, input int act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got 0x%0h expected none (cycle %0d)", nm, act, cyc);
  endtask

  function automatic logic [15:0] model_pixel(input int xx, input int yy);
    logic [6:0] xv;
    logic [5:0] yv;
    xv = 7'(xx);
    yv = 6'(yy);
    if (const_en) return const_val;
    return {xv, yv, 3'b000} ^ key;
  endfunction

  // reference: a frame accepted at the end of cycle c yields NPIX words in raster
  // order and frame_done visible FRAME_CYC+2 cycles after c
  task automatic push_frame(input int c);
    for (int yy = 0; yy < TH_; yy++)
      for (int xx = 0; xx < TW_; xx++)
        exp_q.push_back(model_pixel(xx, yy));
    exp_done_q.push_back(c + FRAME_CYC + 2);
  endtask

  // driver tasks (entered and left at posedge + #1)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic pulse_frame();
    push_frame(cyc);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic pulse_raw();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_frames();
    int budget;
    budget = 4 * FRAME_CYC;
    while (exp_done_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) begin
      fail_now("frame_timeout", exp_done_q.size());
      exp_done_q.delete();
      exp_q.delete();
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_cs_n"}, int'(spi_cs_n), 1);
    check({tag, "_sclk"}, int'(spi_sclk), 1);
    check({tag, "_mosi"}, int'(spi_mosi), 0);
    check({tag, "_dc"}, int'(spi_dc), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(frame_done), 0);
    check({tag, "_xy"}, int'({x, y}), 0);
    check({tag, "_state"}, int'(dbg_state), int'(ST_IDLE));
    tick();
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (in_reset) begin
      nb      = 0;
      low_run = 0;
    end else begin
      if (frame_done) begin
        if (exp_done_q.size() == 0) fail_now("spurious_done", cyc);
        else check("done_cycle", cyc, exp_done_q.pop_front());
        check("done_busy", int'(busy), 0);
        check("done_cs_n", int'(spi_cs_n), 1);
      end
      if (prev_busy && !busy && !frame_done) fail_now("busy_drop", cyc);
      if (!prev_sclk && spi_sclk) begin
        check("low_phase", low_run, TD);
        check("bit_cs_n", int'(spi_cs_n), 0);
        check("bit_dc", int'(spi_dc), 1);
        sh = {sh[14:0], spi_mosi};
        nb++;
        if (nb == 16) begin
          if (exp_q.size() == 0) fail_now("extra_word", int'(sh));
          else check("word", int'(sh), int'(exp_q.pop_front()));
          nb = 0;
        end
      end
      if (x >= 7'(TW_) || y >= 6'(TH_)) fail_now("xy_range", int'({x, y}));
      low_run = spi_sclk ? 0 : low_run + 1;
    end
    prev_sclk = spi_sclk;
    prev_busy = busy;
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: cycle %0d expected finish earlier", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int k;
    reset_n  = 1'b0;
    in_reset = 1'b1;
    repeat (3) tick();
    check_idle("reset");

    // first frame_start right as reset is released, constant red
    const_en  = 1'b1;
    const_val = 16'hF800;
    reset_n   = 1'b1;
    in_reset  = 1'b0;
    pulse_frame();
    wait_frames();
    check_idle("red");
    const_en = 1'b0;

    for (int f = 0; f < 3; f++) begin
      key = 16'($urandom_range(0, 65535));
      repeat ($urandom_range(0, 5)) tick();
      pulse_frame();
      wait_frames();
      check_idle("rand");
    end

    // requests while busy and in the DONE cycle are dropped
    key = 16'($urandom_range(0, 65535));
    k = cyc;
    pulse_frame();
    wait_cyc(k + 100);
    pulse_raw();
    wait_cyc(k + 500);
    pulse_raw();
    wait_cyc(k + FRAME_CYC + 1);
    pulse_raw();
    wait_frames();
    check_idle("ignore");

    // reset during bit 7 of pixel (2,1), then restart from (0,0)
    key = 16'($urandom_range(0, 65535));
    k = cyc;
    pulse_frame();
    wait_cyc(k + 2 + (TW_ + 2) * PIX_CYC + 8 * 2 * TD + 1);
    in_reset = 1'b1;
    exp_q.delete();
    exp_done_q.delete();
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_cs_n", int'(spi_cs_n), 1);
    check("rst_sclk", int'(spi_sclk), 1);
    check("rst_mosi", int'(spi_mosi), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(frame_done), 0);
    check("rst_xy", int'({x, y}), 0);
    tick();
    reset_n  = 1'b1;
    in_reset = 1'b0;
    pulse_frame();
    wait_frames();
    check_idle("restart");

    // frame_start held: two frames separated by one idle cycle
    key = 16'($urandom_range(0, 65535));
    k = cyc;
    push_frame(k);
    push_frame(k + FRAME_CYC + 2);
    frame_start = 1'b1;
    wait_cyc(k + FRAME_CYC + 3);
    frame_start = 1'b0;
    wait_frames();
    check_idle("b2b");

    check("words_left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
